// File: rtl/mlp_feature_frontend.sv
// Stream front end for the combinational printed-MLP core: quantizes raw samples,
// presents a full feature vector, waits for the core to settle, then offers the result.
module mlp_feature_frontend #(
  parameter int NUM_FEAT = 6,
  parameter int IN_W     = 8,
  parameter int Q_W      = 4,
  parameter int RES_W    = 19,
  parameter int SETTLE   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_W-1:0]         s_data,
  input  logic                    s_last,
  output logic [NUM_FEAT*Q_W-1:0] feat_vec,
  input  logic [RES_W-1:0]        res_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RES_W-1:0]        m_data,
  output logic                    frame_err
);

  localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int TMR_W = $clog2(SETTLE + 1);
  localparam int SHIFT = IN_W - Q_W;
  localparam logic [IN_W:0]      RND       = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic [IN_W:0]      QMAX      = (IN_W+1)'((1 << Q_W) - 1);
  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(NUM_FEAT - 1);
  localparam logic [TMR_W-1:0]   SETTLE_LD = TMR_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [TMR_W-1:0]          r_timer;
  logic [NUM_FEAT*Q_W-1:0]   r_shadow;
  logic [NUM_FEAT*Q_W-1:0]   r_feat_vec;
  logic [RES_W-1:0]          r_m_data;
  logic                      r_m_valid;
  logic                      r_frame_err;
  logic [Q_W-1:0]            w_q;

  // Round half up at IN_W+1 bits so the carry is kept, then clamp to the feature range.
  function automatic logic [Q_W-1:0] quantize(input logic [IN_W-1:0] d);
    logic [IN_W:0] sum;
    logic [IN_W:0] shr;
    sum = {1'b0, d} + RND;
    shr = sum >> SHIFT;
    if (shr > QMAX) begin
      return {Q_W{1'b1}};
    end else begin
      return shr[Q_W-1:0];
    end
  endfunction

  // Quantized view of the sample currently on the input bus.
  always_comb begin
    w_q = quantize(s_data);
  end

  assign s_ready   = (r_state == ST_LOAD) || (r_state == ST_DISCARD);
  assign feat_vec  = r_feat_vec;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign frame_err = r_frame_err;

  // Frame assembly, settle timing and result handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_shadow    <= '0;
      r_feat_vec  <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (s_valid) begin
            if (r_cnt == LAST_IDX) begin
              r_cnt <= '0;
              if (s_last) begin
                // Final slot bypasses the shadow so feat_vec changes in one step.
                r_feat_vec <= {w_q, r_shadow[(NUM_FEAT-1)*Q_W-1:0]};
                r_timer    <= SETTLE_LD;
                r_state    <= ST_SETTLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_DISCARD;
              end
            end else if (s_last) begin
              r_frame_err <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_shadow[r_cnt*Q_W +: Q_W] <= w_q;
              r_cnt                      <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DISCARD: begin
          if (s_valid && s_last) begin
            r_state <= ST_LOAD;
          end
        end
        ST_SETTLE: begin
          if (r_timer == '0) begin
            r_m_data  <= res_in;
            r_m_valid <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_feature_frontend.sv
// Directed self-checking bench for mlp_feature_frontend.
module tb_mlp_feature_frontend;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [23:0] feat_vec;
  logic [18:0] res_in;
  logic        m_valid;
  logic        m_ready;
  logic [18:0] m_data;
  logic        frame_err;

  int checks = 0;
  int failures = 0;

  mlp_feature_frontend dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .feat_vec  (feat_vec),
    .res_in    (res_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends n beats, byte i from v[i*8 +: 8], s_last on beat n-1.
  task automatic send_frame(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      send_beat(v[i*8 +: 8], (i == n - 1));
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (m_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, m_valid}, 32'd1);
  endtask

  task automatic handshake(input string tag);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk({tag, "_mvalid_clr"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_sready_back"}, {31'd0, s_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_mdata", {13'd0, m_data}, 32'd0);
    chk("rst_feat", {8'd0, feat_vec}, 32'd0);
    chk("rst_sready", {31'd0, s_ready}, 32'd1);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    res_in  = 19'h00000;
    m_ready = 1'b0;
    tick();
    do_reset();

    // Nominal frame: capture must happen exactly 4 edges after the last accept.
    send_frame(64'h0000_6050_4030_2010, 6);
    chk("nom_feat", {8'd0, feat_vec}, 32'h654321);
    chk("nom_sready_settle", {31'd0, s_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("nom_mvalid_early", {31'd0, m_valid}, 32'd0);
      tick();
    end
    chk("nom_mvalid_early", {31'd0, m_valid}, 32'd0);
    res_in = 19'h1113D;
    tick();
    chk("nom_mvalid", {31'd0, m_valid}, 32'd1);
    chk("nom_mdata", {13'd0, m_data}, 32'h1113D);
    res_in = 19'h00000;
    handshake("nom");

    // Quantize edge values, then 20 cycles of backpressure.
    res_in = 19'h2AAAA;
    send_frame(64'h0000_FFF9_F718_1700, 6);
    chk("q_feat", {8'd0, feat_vec}, 32'hFFF210);
    wait_valid(10, "q_wait");
    chk("q_mdata", {13'd0, m_data}, 32'h2AAAA);
    for (int i = 0; i < 20; i++) begin
      res_in  = 19'(i * 777);
      s_valid = 1'b1;
      s_data  = 8'h33;
      s_last  = 1'b1;
      tick();
      chk("bp_mvalid", {31'd0, m_valid}, 32'd1);
      chk("bp_mdata", {13'd0, m_data}, 32'h2AAAA);
      chk("bp_sready", {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("bp_feat", {8'd0, feat_vec}, 32'hFFF210);
    handshake("bp");

    // Short frame is dropped with a single error pulse.
    send_beat(8'h11, 1'b0);
    chk("short_ferr_b1", {31'd0, frame_err}, 32'd0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    chk("short_ferr", {31'd0, frame_err}, 32'd1);
    tick();
    chk("short_ferr_clr", {31'd0, frame_err}, 32'd0);
    chk("short_feat", {8'd0, feat_vec}, 32'hFFF210);
    chk("short_mvalid", {31'd0, m_valid}, 32'd0);
    chk("short_sready", {31'd0, s_ready}, 32'd1);
    res_in = 19'h12345;
    send_frame(64'h0000_D0C0_B0A0_9080, 6);
    chk("short_next_feat", {8'd0, feat_vec}, 32'hDCBA98);
    wait_valid(10, "short_next_wait");
    chk("short_next_mdata", {13'd0, m_data}, 32'h12345);
    handshake("short_next");

    // Long frame: error after beat 6, beats 7-8 discarded.
    for (int i = 0; i < 8; i++) begin
      send_beat(8'(16 * (i + 1)), (i == 7));
      if (i == 5) chk("long_ferr", {31'd0, frame_err}, 32'd1);
      if (i > 5) chk("long_ferr_once", {31'd0, frame_err}, 32'd0);
    end
    chk("long_sready", {31'd0, s_ready}, 32'd1);
    chk("long_feat", {8'd0, feat_vec}, 32'hDCBA98);
    for (int i = 0; i < 6; i++) tick();
    chk("long_mvalid", {31'd0, m_valid}, 32'd0);
    res_in = 19'h0BEEF;
    send_frame(64'h0000_7060_5040_3020, 6);
    chk("long_next_feat", {8'd0, feat_vec}, 32'h765432);
    wait_valid(10, "long_next_wait");
    chk("long_next_mdata", {13'd0, m_data}, 32'h0BEEF);
    handshake("long_next");

    // Reset while settling.
    res_in = 19'h55555;
    send_frame(64'h0000_6050_4030_2010, 6);
    tick();
    do_reset();
    res_in = 19'h1113D;
    send_frame(64'h0000_6050_4030_2010, 6);
    chk("rs_feat", {8'd0, feat_vec}, 32'h654321);
    for (int i = 0; i < 3; i++) tick();
    chk("rs_mvalid_early", {31'd0, m_valid}, 32'd0);
    tick();
    chk("rs_mvalid", {31'd0, m_valid}, 32'd1);
    chk("rs_mdata", {13'd0, m_data}, 32'h1113D);

    // Reset while holding a pending result.
    tick();
    do_reset();
    res_in = 19'h7ABCD;
    send_frame(64'h0000_6050_4030_2010, 6);
    chk("rh_feat", {8'd0, feat_vec}, 32'h654321);
    wait_valid(10, "rh_wait");
    chk("rh_mdata", {13'd0, m_data}, 32'h7ABCD);
    handshake("rh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
